// File: rtl/br_redirect_ctrl.sv
// Branch redirect controller: turns resolved execute-stage branches into a held
// fetch redirect on mispredict, and queues every accepted branch for predictor update.
module br_redirect_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic [31:0] ex_pc,
    input  logic        ex_ifbr,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        stall_ex,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    output logic [31:0] upd_target,
    input  logic        upd_ready
);

    typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_redir_pc;
    logic        r_flush;
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic [31:0] r_fifo_pc    [4];
    logic        r_fifo_taken [4];
    logic [31:0] r_fifo_tgt   [4];

    logic        w_acc;
    logic        w_mispredict;
    logic [31:0] w_correct_pc;
    logic        w_enter_redir;
    logic        w_redir_hs;
    logic        w_push;
    logic        w_pop;
    logic        w_full;

    assign w_full        = (r_count == 3'd4);
    assign w_acc         = ex_valid & ex_is_br & (r_state == IDLE) & ~w_full;
    assign w_mispredict  = (ex_ifbr != ex_pred_taken) | (ex_ifbr & (ex_target != ex_pred_target));
    assign w_correct_pc  = ex_ifbr ? ex_target : ex_pc + 32'd4;
    assign w_enter_redir = w_acc & w_mispredict;
    assign w_redir_hs    = (r_state == REDIR) & redir_ready;
    // Full blocks the push on the full-count value, even if the head leaves this cycle.
    assign w_push        = w_acc;
    assign w_pop         = (r_count != 3'd0) & upd_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_enter_redir) w_state_nxt = REDIR;
            REDIR: if (w_redir_hs)    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        redir_valid = (r_state == REDIR);
        stall_ex    = (r_state == REDIR) | (ex_valid & ex_is_br & w_full);
    end

    // Redirect target captured once on entry and held until fetch takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_redir_pc <= 32'd0;
            r_flush    <= 1'b0;
        end else begin
            r_flush <= w_enter_redir;
            if (w_enter_redir) r_redir_pc <= w_correct_pc;
        end
    end

    assign flush    = r_flush;
    assign redir_pc = r_redir_pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]    <= ex_pc;
            r_fifo_taken[r_wptr] <= ex_ifbr;
            r_fifo_tgt[r_wptr]   <= ex_target;
        end
    end

    assign upd_valid  = (r_count != 3'd0);
    assign upd_pc     = r_fifo_pc[r_rptr];
    assign upd_taken  = r_fifo_taken[r_rptr];
    assign upd_target = r_fifo_tgt[r_rptr];

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Scoreboard bench for br_redirect_ctrl: stimulus pushes expected redirects and
// predictor updates; independent monitors pop and compare when the DUT presents them.
module tb_br_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_is_br = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_ifbr = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'd0;
    logic        stall_ex;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready = 1'b1;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_ready = 1'b1;

    br_redirect_ctrl dut (
        .clk            (clk),
        .rstn           (rstn),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_pc          (ex_pc),
        .ex_ifbr        (ex_ifbr),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .stall_ex       (stall_ex),
        .flush          (flush),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .redir_ready    (redir_ready),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_ready      (upd_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } upd_t;

    upd_t        upd_q[$];
    logic [31:0] redir_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    // Call just after a rising edge (or sync=1). Returns just after the accepting edge.
    task automatic issue(input bit sync, input logic [31:0] pc, input logic ifbr,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input bit exp_redir, input logic [31:0] exp_pc, output int waited);
        upd_t e;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = pc; ex_ifbr = ifbr;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
        waited = 0;
        @(negedge clk);
        while (stall_ex && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (stall_ex) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout pc=0x%08h: stall_ex still 1, required accept", pc);
            ex_valid = 1'b0;
            ex_is_br = 1'b0;
        end else begin
            e.pc = pc; e.taken = ifbr; e.tgt = tgt;
            upd_q.push_back(e);
            if (exp_redir) redir_q.push_back(exp_pc);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic after_accept(input logic exp_redir, input string tag);
        ex_valid = 1'b0;
        ex_is_br = 1'b0;
        @(negedge clk);
        check($sformatf("%s_redir_valid", tag), redir_valid, exp_redir);
        check($sformatf("%s_flush", tag), flush, exp_redir);
        check($sformatf("%s_upd_valid", tag), upd_valid, 1);
    endtask

    // Redirect monitor
    initial begin
        logic        prev_rv;
        logic [31:0] held_pc;
        prev_rv = 1'b0;
        held_pc = 32'd0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_rv = 1'b0;
            end else begin
                if (redir_valid && !prev_rv) begin
                    check("flush_first_cycle", flush, 1);
                    check("stall_in_redir", stall_ex, 1);
                    if (redir_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL redir_unexpected: got 0x%08h required none", redir_pc);
                    end else begin
                        check("redir_pc", redir_pc, redir_q.pop_front());
                    end
                    held_pc = redir_pc;
                end else if (redir_valid) begin
                    check("flush_one_pulse", flush, 0);
                    check("redir_pc_stable", redir_pc, held_pc);
                    check("stall_held", stall_ex, 1);
                end
                prev_rv = redir_valid;
            end
        end
    end

    // Predictor-update monitor
    initial begin
        upd_t e;
        forever begin
            @(negedge clk);
            if (rstn && upd_valid && upd_ready) begin
                if (upd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected: got pc 0x%08h required none", upd_pc);
                end else begin
                    e = upd_q.pop_front();
                    check("upd_pc", upd_pc, e.pc);
                    check("upd_taken", upd_taken, e.taken);
                    check("upd_target", upd_target, e.tgt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        #1 rstn = 1'b0;
        #1;
        check("rst_redir_valid", redir_valid, 0);
        check("rst_redir_pc", redir_pc, 0);
        check("rst_flush", flush, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_stall", stall_ex, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Correctly predicted taken branch
        issue(1, 32'h100, 1, 32'h140, 1, 32'h140, 0, 32'h0, w);
        after_accept(0, "correct");

        // Non-branch passes without action
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_is_br = 1'b0; ex_pc = 32'h180;
        @(negedge clk);
        check("nonbr_stall", stall_ex, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("nonbr_upd_valid", upd_valid, 0);
        check("nonbr_redir_valid", redir_valid, 0);

        // Direction mispredict with fetch back-pressure
        @(posedge clk); #1;
        redir_ready = 1'b0;
        issue(0, 32'h200, 0, 32'h208, 1, 32'h208, 1, 32'h204, w);
        after_accept(1, "dir");
        repeat (2) begin
            @(negedge clk);
            check("dir_hold_valid", redir_valid, 1);
            check("dir_hold_stall", stall_ex, 1);
        end
        @(posedge clk); #1;
        redir_ready = 1'b1;
        @(negedge clk);
        check("dir_hs_valid", redir_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("dir_post_hs_valid", redir_valid, 0);
        check("dir_post_hs_stall", stall_ex, 0);

        // Target mispredict, fetch ready immediately
        issue(1, 32'h280, 1, 32'h300, 1, 32'h380, 1, 32'h300, w);
        after_accept(1, "tgt");
        @(negedge clk);
        check("tgt_post_hs_valid", redir_valid, 0);
        check("tgt_post_hs_stall", stall_ex, 0);

        // PC+4 wraps to zero
        issue(1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 1, 32'h0, w);
        after_accept(1, "wrap");
        @(negedge clk);
        check("wrap_post_hs_valid", redir_valid, 0);

        // FIFO full: four accepted back-to-back, fifth stalls until a pop frees a slot
        @(posedge clk); #1;
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 32'h400 + 32'(i) * 32'h10, 1, 32'h420 + 32'(i) * 32'h10, 1,
                  32'h420 + 32'(i) * 32'h10, 0, 32'h0, w);
            check($sformatf("full_b2b_wait%0d", i), w, 0);
        end
        ex_pc = 32'h440; ex_target = 32'h460; ex_pred_target = 32'h460;
        @(negedge clk);
        check("full_stall", stall_ex, 1);
        check("full_upd_valid", upd_valid, 1);
        @(posedge clk); #1;
        upd_ready = 1'b1;
        @(negedge clk);
        check("full_pop_cycle_stall", stall_ex, 1);
        @(posedge clk); #1;
        upd_ready = 1'b0;
        @(negedge clk);
        check("full_after_pop_stall", stall_ex, 0);
        begin
            upd_t e;
            e.pc = 32'h440; e.taken = 1'b1; e.tgt = 32'h460;
            upd_q.push_back(e);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_br = 1'b0;
        upd_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (upd_valid && n < 20);
        check("full_drained", upd_valid, 0);
        check("full_q_empty", upd_q.size(), 0);

        // Asynchronous reset while redirecting with two queued updates
        @(posedge clk); #1;
        upd_ready = 1'b0;
        redir_ready = 1'b0;
        issue(0, 32'h500, 1, 32'h520, 1, 32'h520, 0, 32'h0, w);
        issue(0, 32'h600, 0, 32'h640, 1, 32'h640, 1, 32'h604, w);
        after_accept(1, "rst_setup");
        @(posedge clk); #3;
        check("rst_setup_stall", stall_ex, 1);
        rstn = 1'b0;
        upd_q.delete();
        redir_q.delete();
        #1;
        check("async_rst_redir_valid", redir_valid, 0);
        check("async_rst_upd_valid", upd_valid, 0);
        check("async_rst_stall", stall_ex, 0);
        check("async_rst_flush", flush, 0);
        check("async_rst_redir_pc", redir_pc, 0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        redir_ready = 1'b1;
        upd_ready = 1'b1;
        issue(0, 32'h700, 1, 32'h720, 1, 32'h720, 0, 32'h0, w);
        check("post_rst_first_edge", w, 0);
        after_accept(0, "post_rst");

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((upd_valid || redir_valid) && n < 20);
        check("end_upd_q_empty", upd_q.size(), 0);
        check("end_redir_q_empty", redir_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
